piso_shift_4bit: RTL and testbench



---
 rtl/piso_pkg.sv | 19 +
 rtl/piso_shift_4bit_bit_counter.sv | 30 +++
 rtl/piso_shift_4bit.sv | 92 +++++++++
 tb/tb_piso_shift_4bit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared types and sizing helpers for the PISO transmit register
// Frame length depends on PISO_PARITY_EN.
package piso_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

  function automatic int frame_len(input int width);
`ifdef PISO_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_shift_4bit_bit_counter.sv
// rtl/piso_shift_4bit_bit_counter.sv - loadable down-counter with zero/one flags
// Load wins over decrement; it saturates at zero.
module bit_counter #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_value,
  input  logic          dec,
  output logic          zero,
  output logic          one
);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign zero = (count == '0);
  assign one  = (count == CW'(1));

endmodule

// File: rtl/piso_shift_4bit.sv
// rtl/piso_shift_4bit.sv - parallel-in serial-out transmitter, MSB first
// Optional even-parity trailer bit when PISO_PARITY_EN is defined.
module piso_shift_4bit
  import piso_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] LOAD_CNT = CW'(frame_len(WIDTH) - 1);

  state_t           state;
  // Bits still to be sent after the MSB, which goes straight to sout on load.
  logic [WIDTH-2:0] pending;
  logic             cnt_zero;
  logic             cnt_one;
  logic             accept;
  logic             cnt_dec;
`ifdef PISO_PARITY_EN
  logic             par;
`endif

  assign load_ready = !rst && ((state == IDLE) || (sout_valid && sout_last));
  assign accept     = load_valid && load_ready;
  assign cnt_dec    = (state != IDLE) && !cnt_zero;

  bit_counter #(.CW(CW)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .load_value (LOAD_CNT),
    .dec        (cnt_dec),
    .zero       (cnt_zero),
    .one        (cnt_one)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pending    <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      sout_last  <= 1'b0;
      busy       <= 1'b0;
`ifdef PISO_PARITY_EN
      par        <= 1'b0;
`endif
    end else if (accept) begin
      state      <= SHIFT;
      pending    <= d[WIDTH-2:0];
      sout       <= d[WIDTH-1];
      sout_valid <= 1'b1;
      sout_last  <= 1'b0;
      busy       <= 1'b1;
`ifdef PISO_PARITY_EN
      par        <= ^d;
`endif
    end else if ((state == SHIFT) && !cnt_zero) begin
`ifdef PISO_PARITY_EN
      if (cnt_one) begin
        state     <= PARITY;
        sout      <= par;
        sout_last <= 1'b1;
      end else begin
        pending <= pending << 1;
        sout    <= pending[WIDTH-2];
      end
`else
      pending   <= pending << 1;
      sout      <= pending[WIDTH-2];
      sout_last <= cnt_one;
`endif
    end else begin
      state      <= IDLE;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      sout_last  <= 1'b0;
      busy       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_piso_shift_4bit.sv
// tb/tb_piso_shift_4bit.sv - self-checking bench for piso_shift_4bit (WIDTH 4 and 8)
module tb_piso_shift_4bit;

  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic sel8;
  logic lv_x;
  logic [15:0] d_x;

  logic [W-1:0] d;
  logic load_valid, load_ready, sout, sout_valid, sout_last, busy;
  logic [7:0] d8;
  logic lv8, lr8, s8, sv8, sl8, b8;
  logic o_ready, o_sout, o_valid, o_last, o_busy;

  int vectors = 0;
  int errors  = 0;

  logic [15:0] words_q[$];
  logic        exp_bit[$];
  logic        exp_last[$];

  always #5 clk = ~clk;

  assign d          = d_x[W-1:0];
  assign d8         = d_x[7:0];
  assign load_valid = lv_x & ~sel8;
  assign lv8        = lv_x & sel8;
  assign o_ready    = sel8 ? lr8 : load_ready;
  assign o_sout     = sel8 ? s8  : sout;
  assign o_valid    = sel8 ? sv8 : sout_valid;
  assign o_last     = sel8 ? sl8 : sout_last;
  assign o_busy     = sel8 ? b8  : busy;

  piso_shift_4bit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .d(d), .load_valid(load_valid), .load_ready(load_ready),
    .sout(sout), .sout_valid(sout_valid), .sout_last(sout_last), .busy(busy)
  );

  piso_shift_4bit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .d(d8), .load_valid(lv8), .load_ready(lr8),
    .sout(s8), .sout_valid(sv8), .sout_last(sl8), .busy(b8)
  );

  // Reference: a frame is the word MSB..LSB, then its even parity if enabled.
  task automatic push_frame(input logic [15:0] w, input int width);
    logic p = 1'b0;
    for (int i = width - 1; i >= 0; i--) begin
      exp_bit.push_back(w[i]);
      exp_last.push_back(!PAR && (i == 0));
      p ^= w[i];
    end
    if (PAR) begin
      exp_bit.push_back(p);
      exp_last.push_back(1'b1);
    end
  endtask

  task automatic check_idle(input string name);
    vectors++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_sout !== 1'b0 || o_last !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s idle: valid=%b busy=%b sout=%b last=%b ready=%b, want 0 0 0 0 1",
               name, o_valid, o_busy, o_sout, o_last, o_ready);
    end
  endtask

  task automatic run_stream(input string name, input bit pulse_mid);
    int  idx = 0;
    int  acc = 0;
    int  wdt;
    int  budget;
    int  bitn = 0;
    bit  started = 1'b0;
    bit  will;
    logic e, el;
    wdt = sel8 ? 8 : W;
    exp_bit.delete();
    exp_last.delete();
    foreach (words_q[i]) push_frame(words_q[i], wdt);
    budget = words_q.size() * (wdt + 2) + 10;
    lv_x = 1'b1;
    d_x  = words_q[0];
    #1;
    will = o_ready && lv_x;
    for (int c = 0; c < budget && (!started || exp_bit.size() > 0); c++) begin
      @(negedge clk);
      if (will) begin
        acc++;
        idx++;
        started = 1'b1;
      end
      if (started) begin
        e  = exp_bit.pop_front();
        el = exp_last.pop_front();
        vectors++;
        if (o_valid !== 1'b1 || o_sout !== e || o_last !== el || o_busy !== 1'b1 || o_ready !== el) begin
          errors++;
          $display("FAIL %s bit%0d: valid=%b sout=%b last=%b busy=%b ready=%b, want 1 %b %b 1 %b",
                   name, bitn, o_valid, o_sout, o_last, o_busy, o_ready, e, el, el);
        end
        bitn++;
      end
      if (idx < words_q.size()) begin
        lv_x = 1'b1;
        d_x  = words_q[idx];
      end else if (pulse_mid && exp_bit.size() >= 2) begin
        lv_x = 1'b1;
        d_x  = 16'hFFFF;
      end else begin
        lv_x = 1'b0;
        d_x  = 16'($urandom);
      end
      #1;
      will = o_ready && lv_x;
    end
    vectors++;
    if (exp_bit.size() != 0) begin
      errors++;
      $display("FAIL %s timeout: %0d bits left, want 0", name, exp_bit.size());
    end
    vectors++;
    if (acc != words_q.size()) begin
      errors++;
      $display("FAIL %s accepts: got %0d, want %0d", name, acc, words_q.size());
    end
    lv_x = 1'b0;
    @(negedge clk);
    check_idle(name);
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    lv_x = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (load_ready !== 1'b0 || sout_valid !== 1'b0 || busy !== 1'b0 || sout !== 1'b0 || sout_last !== 1'b0) begin
        errors++;
        $display("FAIL reset_init: ready=%b valid=%b busy=%b sout=%b last=%b, want all 0",
                 load_ready, sout_valid, busy, sout, sout_last);
      end
    end
    rst  = 1'b0;
    lv_x = 1'b0;
    #1;
    check_idle("reset_release");
  endtask

  task automatic test_single();
    words_q = '{16'h000B};
    run_stream("single_1011", 1'b0);
  endtask

  task automatic test_back_to_back();
    words_q = '{16'h000A, 16'h0005};
    run_stream("b2b_A5", 1'b0);
  endtask

  task automatic test_mid_pulse();
    words_q = '{16'h000A};
    run_stream("mid_pulse", 1'b1);
  endtask

  task automatic test_parity_words();
    words_q = '{16'h0007};
    run_stream("word_0111", 1'b0);
    words_q = '{16'h0006};
    run_stream("word_0110", 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 20; t++) begin
      words_q.delete();
      for (int k = 0; k < int'($urandom_range(1, 3)); k++)
        words_q.push_back(16'($urandom_range(0, (1 << W) - 1)));
      run_stream($sformatf("rand%0d", t), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    lv_x = 1'b1;
    d_x  = 16'($urandom);
    @(negedge clk);
    lv_x = 1'b0;
    @(negedge clk);
    rst  = 1'b1;
    lv_x = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (load_ready !== 1'b0 || sout_valid !== 1'b0 || busy !== 1'b0 || sout !== 1'b0 || sout_last !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid: ready=%b valid=%b busy=%b sout=%b last=%b, want all 0",
                 load_ready, sout_valid, busy, sout, sout_last);
      end
    end
    rst  = 1'b0;
    lv_x = 1'b0;
    #1;
    check_idle("reset_mid_release");
    @(negedge clk);
    check_idle("reset_mid_after");
  endtask

  task automatic test_width8();
    sel8 = 1'b1;
    words_q = '{16'h00C3};
    run_stream("w8_C3", 1'b0);
    words_q = '{16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255))};
    run_stream("w8_rand", 1'b1);
    sel8 = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    sel8 = 1'b0;
    lv_x = 1'b0;
    d_x  = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_mid_pulse();
    test_parity_words();
    test_random();
    test_reset_mid();
    test_width8();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
